// File: rtl/tm1638_scheduler.sv
// Refresh/poll scheduler for a TM1638 front panel: streams dirty shadow bytes
// to the serial driver one at a time and interleaves periodic key scans.
module tm1638_scheduler #(
    parameter int unsigned POLL_PERIOD = 50000
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       BUF_WE,
    input  logic [3:0] BUF_ADDR,
    input  logic [7:0] BUF_DATA,
    output logic [7:0] KEYS,
    output logic       KEY_EVENT,
    output logic       BUSY,
    input  logic       DRV_READY,
    output logic       DRV_WRITE,
    output logic       DRV_READ,
    output logic [3:0] DRV_ADDR,
    output logic [7:0] DRV_DATA,
    input  logic [7:0] DRV_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_BUSY,
        S_RD_REQ,
        S_RD_BUSY
    } state_t;

    localparam logic [15:0] LP_TIMER_LAST = 16'(POLL_PERIOD - 1);

    state_t      r_state;
    logic [7:0]  r_shadow [16];
    logic [15:0] r_dirty;
    logic [3:0]  r_ptr;
    logic [15:0] r_timer;
    logic        r_poll_pending;
    logic [7:0]  r_keys;
    logic        r_key_event;
    logic        r_drv_write;
    logic        r_drv_read;
    logic [3:0]  r_drv_addr;
    logic [7:0]  r_drv_data;

    logic [31:0] w_dirty_dbl;
    logic [15:0] w_dirty_rot;
    logic [3:0]  w_offset;
    logic [3:0]  w_sel;
    logic        w_any_dirty;
    logic        w_issue_wr;
    logic        w_wrap;
    logic [15:0] w_dirty_set;
    logic [15:0] w_dirty_clr;

    // Rotate the dirty mask so bit 0 is the scan pointer; the lowest set bit
    // of the rotated mask is then the next entry in round-robin order.
    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dirty_dbl = {r_dirty, r_dirty} >> r_ptr;
        w_dirty_rot = w_dirty_dbl[15:0];
        w_offset    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_dirty_rot[i]) begin
                w_offset = 4'(i);
            end
        end
        w_sel = r_ptr + w_offset;
    end

    assign w_any_dirty = |r_dirty;
    assign w_issue_wr  = (r_state == S_IDLE) && DRV_READY && !r_poll_pending && w_any_dirty;
    assign w_wrap      = (r_timer == LP_TIMER_LAST);
    assign w_dirty_set = BUF_WE ? (16'h0001 << BUF_ADDR) : 16'h0000;
    assign w_dirty_clr = w_issue_wr ? (16'h0001 << w_sel) : 16'h0000;

    // NOTE: the shadow is a small flop array and is reset on purpose so the
    // forced post-reset flush blanks the display; a RAM-backed store would not be.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_state        <= S_IDLE;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= 8'h00;
            end
            r_dirty        <= 16'hFFFF;
            r_ptr          <= 4'd0;
            r_timer        <= 16'd0;
            r_poll_pending <= 1'b0;
            r_keys         <= 8'h00;
            r_key_event    <= 1'b0;
            r_drv_write    <= 1'b0;
            r_drv_read     <= 1'b0;
            r_drv_addr     <= 4'd0;
            r_drv_data     <= 8'h00;
        end else begin
            r_timer <= w_wrap ? 16'd0 : r_timer + 16'd1;
            // A wrap that lands while a poll is still pending is simply lost.
            if (r_state == S_RD_REQ && r_poll_pending) begin
                r_poll_pending <= 1'b0;
            end else if (w_wrap) begin
                r_poll_pending <= 1'b1;
            end

            if (BUF_WE) begin
                r_shadow[BUF_ADDR] <= BUF_DATA;
            end
            // Set is OR-ed after the clear so a same-cycle host write re-arms the entry.
            r_dirty     <= (r_dirty & ~w_dirty_clr) | w_dirty_set;
            r_key_event <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (DRV_READY && r_poll_pending) begin
                        r_drv_read <= 1'b1;
                        r_state    <= S_RD_REQ;
                    end else if (w_issue_wr) begin
                        r_drv_addr  <= w_sel;
                        r_drv_data  <= r_shadow[w_sel];
                        r_ptr       <= w_sel + 4'd1;
                        r_drv_write <= 1'b1;
                        r_state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!DRV_READY) begin
                        r_drv_write <= 1'b0;
                        r_state     <= S_WR_BUSY;
                    end
                end
                S_WR_BUSY: begin
                    if (DRV_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (!DRV_READY) begin
                        r_drv_read <= 1'b0;
                        r_state    <= S_RD_BUSY;
                    end
                end
                S_RD_BUSY: begin
                    if (DRV_READY) begin
                        r_keys      <= DRV_RDATA;
                        r_key_event <= (DRV_RDATA != r_keys);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign KEYS      = r_keys;
    assign KEY_EVENT = r_key_event;
    assign BUSY      = (r_state != S_IDLE) || w_any_dirty;
    assign DRV_WRITE = r_drv_write;
    assign DRV_READ  = r_drv_read;
    assign DRV_ADDR  = r_drv_addr;
    assign DRV_DATA  = r_drv_data;

endmodule

// File: tb/tb_tm1638_scheduler.sv
// Directed bench for tm1638_scheduler with a simple driver model that drops
// READY for three cycles after each accepted command.
module tb_tm1638_scheduler;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    logic       CLK_IN = 1'b0;
    logic       RST_IN;
    logic       BUF_WE;
    logic [3:0] BUF_ADDR;
    logic [7:0] BUF_DATA;
    logic [7:0] KEYS;
    logic       KEY_EVENT;
    logic       BUSY;
    logic       DRV_READY;
    logic       DRV_WRITE;
    logic       DRV_READ;
    logic [3:0] DRV_ADDR;
    logic [7:0] DRV_DATA;
    logic [7:0] DRV_RDATA;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ev_cnt = 0;
    int   overlap_cnt = 0;
    logic [7:0] key_val = 8'h00;
    wr_t  wr_q[$];
    int   rd_q[$];

    tm1638_scheduler #(.POLL_PERIOD(16)) dut (
        .CLK_IN    (CLK_IN),
        .RST_IN    (RST_IN),
        .BUF_WE    (BUF_WE),
        .BUF_ADDR  (BUF_ADDR),
        .BUF_DATA  (BUF_DATA),
        .KEYS      (KEYS),
        .KEY_EVENT (KEY_EVENT),
        .BUSY      (BUSY),
        .DRV_READY (DRV_READY),
        .DRV_WRITE (DRV_WRITE),
        .DRV_READ  (DRV_READ),
        .DRV_ADDR  (DRV_ADDR),
        .DRV_DATA  (DRV_DATA),
        .DRV_RDATA (DRV_RDATA)
    );

    initial forever #5 CLK_IN = ~CLK_IN;
    initial forever begin
        @(posedge CLK_IN);
        cyc++;
    end

    // Driver model: accept on a request seen with READY high, hold READY low 3 cycles.
    initial begin
        int  cnt;
        wr_t t;
        cnt       = 0;
        DRV_READY = 1'b1;
        DRV_RDATA = 8'h00;
        forever begin
            @(negedge CLK_IN);
            DRV_RDATA = key_val;
            if (DRV_WRITE && DRV_READ) overlap_cnt++;
            if (KEY_EVENT) ev_cnt++;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) DRV_READY = 1'b1;
            end else if (DRV_READY && !RST_IN && (DRV_WRITE || DRV_READ)) begin
                if (DRV_WRITE) begin
                    t.a = DRV_ADDR;
                    t.d = DRV_DATA;
                    t.c = cyc;
                    wr_q.push_back(t);
                end else begin
                    rd_q.push_back(cyc);
                end
                DRV_READY = 1'b0;
                cnt       = 3;
            end
        end
    end

    task automatic tick();
        @(negedge CLK_IN);
        #2;
    endtask

    task automatic buf_write(input logic [3:0] a, input logic [7:0] d);
        BUF_WE   = 1'b1;
        BUF_ADDR = a;
        BUF_DATA = d;
        tick();
        BUF_WE   = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int k = 0; k < budget && wr_q.size() < n; k++) tick();
    endtask

    task automatic wait_reads(input int n, input int budget);
        for (int k = 0; k < budget && rd_q.size() < n; k++) tick();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && BUSY !== 1'b0; k++) tick();
    endtask

    task automatic test_reset();
        RST_IN = 1'b1;
        repeat (3) tick();
        checks++; if (KEYS !== 8'h00)    begin errors++; $display("FAIL reset_keys: got %h want 00", KEYS); end
        checks++; if (KEY_EVENT !== 1'b0) begin errors++; $display("FAIL reset_key_event: got %b want 0", KEY_EVENT); end
        checks++; if (DRV_WRITE !== 1'b0) begin errors++; $display("FAIL reset_drv_write: got %b want 0", DRV_WRITE); end
        checks++; if (DRV_READ !== 1'b0)  begin errors++; $display("FAIL reset_drv_read: got %b want 0", DRV_READ); end
        checks++; if (DRV_ADDR !== 4'h0)  begin errors++; $display("FAIL reset_drv_addr: got %h want 0", DRV_ADDR); end
        checks++; if (DRV_DATA !== 8'h00) begin errors++; $display("FAIL reset_drv_data: got %h want 00", DRV_DATA); end
        checks++; if (BUSY !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b want 1", BUSY); end
        wr_q.delete();
        rd_q.delete();
        RST_IN = 1'b0;
    endtask

    task automatic check_flush(input int base, input string tag);
        wait_writes(base + 16, 400);
        checks++;
        if (wr_q.size() < base + 16) begin
            errors++; $display("FAIL %s_count: got %0d writes want %0d", tag, wr_q.size() - base, 16);
        end
        for (int i = 0; i < 16; i++) begin
            if (base + i < wr_q.size()) begin
                checks++;
                if (wr_q[base+i].a !== 4'(i) || wr_q[base+i].d !== 8'h00) begin
                    errors++;
                    $display("FAIL %s_entry%0d: got addr %h data %h want addr %h data 00",
                             tag, i, wr_q[base+i].a, wr_q[base+i].d, i);
                end
            end
        end
        wait_idle(60);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, BUSY); end
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL %s_extra: got %0d writes want 16", tag, wr_q.size() - base);
        end
    endtask

    task automatic test_flush();
        check_flush(0, "flush");
    endtask

    task automatic test_key_scan();
        int n0;
        int ev0;
        key_val = 8'h21;
        n0  = rd_q.size();
        ev0 = ev_cnt;
        wait_reads(n0 + 3, 80);
        repeat (8) tick();
        checks++; if (KEYS !== 8'h21) begin errors++; $display("FAIL keys_value: got %h want 21", KEYS); end
        checks++; if (ev_cnt - ev0 != 1) begin errors++; $display("FAIL key_event_count: got %0d want 1", ev_cnt - ev0); end
        checks++;
        if (rd_q.size() < n0 + 3) begin
            errors++; $display("FAIL poll_count: got %0d reads want 3", rd_q.size() - n0);
        end else if (rd_q[n0+2] - rd_q[n0+1] != 16) begin
            errors++; $display("FAIL poll_period: got %0d cycles want 16", rd_q[n0+2] - rd_q[n0+1]);
        end
    endtask

    task automatic test_rotation();
        int n0;
        n0 = wr_q.size();
        buf_write(4'd4, 8'h44);
        wait_writes(n0 + 1, 40);
        buf_write(4'd2, 8'h22);
        buf_write(4'd9, 8'h99);
        wait_writes(n0 + 3, 80);
        checks++;
        if (wr_q.size() < n0 + 3) begin
            errors++; $display("FAIL rot_count: got %0d writes want 3", wr_q.size() - n0);
        end else begin
            checks++;
            if (wr_q[n0].a !== 4'd4 || wr_q[n0].d !== 8'h44) begin
                errors++; $display("FAIL rot_first: got %h/%h want 4/44", wr_q[n0].a, wr_q[n0].d);
            end
            checks++;
            if (wr_q[n0+1].a !== 4'd9 || wr_q[n0+1].d !== 8'h99) begin
                errors++; $display("FAIL rot_second: got %h/%h want 9/99", wr_q[n0+1].a, wr_q[n0+1].d);
            end
            checks++;
            if (wr_q[n0+2].a !== 4'd2 || wr_q[n0+2].d !== 8'h22) begin
                errors++; $display("FAIL rot_third: got %h/%h want 2/22", wr_q[n0+2].a, wr_q[n0+2].d);
            end
        end
        wait_idle(60);
    endtask

    task automatic test_collision();
        int n0;
        n0 = wr_q.size();
        buf_write(4'd3, 8'hAA);
        wait_writes(n0 + 1, 40);
        tick();
        buf_write(4'd3, 8'h55);
        wait_writes(n0 + 2, 60);
        checks++;
        if (wr_q.size() < n0 + 2) begin
            errors++; $display("FAIL coll_count: got %0d writes want 2", wr_q.size() - n0);
        end else begin
            checks++;
            if (wr_q[n0].a !== 4'd3 || wr_q[n0].d !== 8'hAA) begin
                errors++; $display("FAIL coll_first: got %h/%h want 3/aa", wr_q[n0].a, wr_q[n0].d);
            end
            checks++;
            if (wr_q[n0+1].a !== 4'd3 || wr_q[n0+1].d !== 8'h55) begin
                errors++; $display("FAIL coll_second: got %h/%h want 3/55", wr_q[n0+1].a, wr_q[n0+1].d);
            end
        end
        wait_idle(60);
    endtask

    task automatic test_same_cycle();
        int n0;
        wait_reads(rd_q.size() + 1, 40);
        wait_idle(20);
        n0 = wr_q.size();
        buf_write(4'd6, 8'h11);
        buf_write(4'd6, 8'h22);
        wait_writes(n0 + 2, 60);
        checks++;
        if (wr_q.size() < n0 + 2) begin
            errors++; $display("FAIL same_count: got %0d writes want 2", wr_q.size() - n0);
        end else begin
            checks++;
            if (wr_q[n0].a !== 4'd6 || wr_q[n0].d !== 8'h11) begin
                errors++; $display("FAIL same_first: got %h/%h want 6/11", wr_q[n0].a, wr_q[n0].d);
            end
            checks++;
            if (wr_q[n0+1].a !== 4'd6 || wr_q[n0+1].d !== 8'h22) begin
                errors++; $display("FAIL same_second: got %h/%h want 6/22", wr_q[n0+1].a, wr_q[n0+1].d);
            end
        end
        wait_idle(60);
    endtask

    task automatic test_priority();
        int r0;
        int w0;
        wait_reads(rd_q.size() + 1, 40);
        wait_idle(20);
        r0 = rd_q.size();
        w0 = wr_q.size();
        for (int i = 8; i < 16; i++) buf_write(4'(i), 8'(8'h80 + i));
        wait_writes(w0 + 8, 200);
        wait_idle(60);
        checks++;
        if (wr_q.size() < w0 + 8 || rd_q.size() <= r0 || r0 == 0) begin
            errors++; $display("FAIL prio_count: got %0d writes %0d reads want 8 writes and a read",
                               wr_q.size() - w0, rd_q.size() - r0);
        end else begin
            checks++;
            if (rd_q[r0] - rd_q[r0-1] > 21) begin
                errors++; $display("FAIL prio_gap: got %0d cycles want at most 21", rd_q[r0] - rd_q[r0-1]);
            end
            checks++;
            if (!(wr_q[w0].c < rd_q[r0] && wr_q[w0+7].c > rd_q[r0])) begin
                errors++; $display("FAIL prio_order: got read at %0d writes %0d..%0d want read inside the burst",
                                   rd_q[r0], wr_q[w0].c, wr_q[w0+7].c);
            end
        end
    endtask

    task automatic test_reset_rd_busy();
        int ev0;
        int w0;
        checks++; if (KEYS !== 8'h21) begin errors++; $display("FAIL rst_pre_keys: got %h want 21", KEYS); end
        wait_reads(rd_q.size() + 1, 40);
        tick();
        RST_IN = 1'b1;
        tick();
        RST_IN  = 1'b0;
        key_val = 8'h00;
        ev0 = ev_cnt;
        w0  = wr_q.size();
        checks++; if (KEYS !== 8'h00)     begin errors++; $display("FAIL rst_keys: got %h want 00", KEYS); end
        checks++; if (DRV_READ !== 1'b0)  begin errors++; $display("FAIL rst_drv_read: got %b want 0", DRV_READ); end
        checks++; if (KEY_EVENT !== 1'b0) begin errors++; $display("FAIL rst_key_event: got %b want 0", KEY_EVENT); end
        checks++; if (BUSY !== 1'b1)      begin errors++; $display("FAIL rst_busy: got %b want 1", BUSY); end
        check_flush(w0, "reflush");
        checks++; if (ev_cnt != ev0) begin errors++; $display("FAIL rst_events: got %0d want 0", ev_cnt - ev0); end
    endtask

    initial begin
        RST_IN   = 1'b1;
        BUF_WE   = 1'b0;
        BUF_ADDR = 4'd0;
        BUF_DATA = 8'h00;
        test_reset();
        test_flush();
        test_key_scan();
        test_rotation();
        test_collision();
        test_same_cycle();
        test_priority();
        test_reset_rd_busy();
        checks++;
        if (overlap_cnt != 0) begin
            errors++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", overlap_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
